// File: rtl/eth_packet_checker.sv
// eth_packet_checker: RX checker for the 10G example generator pattern.
// `define PKT_CHK_GAP_STATS_EN adds min_gap/max_gap inter-packet gap stats.
module eth_packet_checker #(
  parameter int CNT_WIDTH = 32
`ifdef PKT_CHK_GAP_STATS_EN
  ,
  parameter int GAP_WIDTH = 16
`endif
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  input  logic [63:0]          s00_axis_tdata,
  input  logic [7:0]           s00_axis_tkeep,
  input  logic                 s00_axis_tvalid,
  input  logic                 s00_axis_tlast,
  input  logic                 s00_axis_tuser,
  input  logic [15:0]          packet_length,
  input  logic [47:0]          expected_data,
  input  logic                 clear_counters,
  output logic [CNT_WIDTH-1:0] rx_pkt_count,
  output logic [CNT_WIDTH-1:0] good_pkt_count,
  output logic [CNT_WIDTH-1:0] seq_err_count,
  output logic [CNT_WIDTH-1:0] data_err_count,
  output logic [CNT_WIDTH-1:0] keep_err_count,
  output logic [CNT_WIDTH-1:0] len_err_count,
  output logic [CNT_WIDTH-1:0] user_err_count,
  output logic [4:0]           last_err_flags,
  output logic                 err_pulse
`ifdef PKT_CHK_GAP_STATS_EN
  ,
  output logic [GAP_WIDTH-1:0] min_gap,
  output logic [GAP_WIDTH-1:0] max_gap
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_PKT,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0] r_idx;
  logic [15:0] r_len_q;
  logic [47:0] r_dat_q;
  logic [4:0]  r_flags;

  logic [CNT_WIDTH-1:0] r_rx_cnt;
  logic [CNT_WIDTH-1:0] r_good_cnt;
  logic [CNT_WIDTH-1:0] r_seq_cnt;
  logic [CNT_WIDTH-1:0] r_dat_cnt;
  logic [CNT_WIDTH-1:0] r_kep_cnt;
  logic [CNT_WIDTH-1:0] r_len_cnt;
  logic [CNT_WIDTH-1:0] r_usr_cnt;
  logic [4:0]           r_last_flags;
  logic                 r_err_pulse;

  logic        w_beat;
  logic        w_fin;
  logic        w_start;
  logic        w_chk;
  logic [15:0] w_len;
  logic [47:0] w_exp;
  logic        w_seq_e;
  logic        w_dat_e;
  logic        w_kep_e;
  logic        w_len_e;
  logic        w_usr_e;
  logic [4:0]  w_flags;
  logic        w_any;

  function automatic logic [CNT_WIDTH-1:0] f_inc(
    input logic [CNT_WIDTH-1:0] v,
    input logic                 en
  );
    f_inc = (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign w_beat  = s00_axis_tvalid;
  assign w_fin   = w_beat & s00_axis_tlast;
  assign w_start = w_beat & (r_state == S_IDLE);
  assign w_chk   = w_beat & (r_state != S_DROP);

  // The first beat is checked against the live inputs it latches.
  assign w_len = w_start ? packet_length : r_len_q;
  assign w_exp = w_start ? expected_data : r_dat_q;

  assign w_seq_e = w_chk & (s00_axis_tdata[15:0] != r_idx);
  assign w_dat_e = w_chk & (s00_axis_tdata[63:16] != w_exp);
  assign w_kep_e = w_chk & (s00_axis_tkeep != 8'hFF);
  assign w_len_e = w_chk & (s00_axis_tlast ?
                            (r_idx < w_len) :
                            (r_idx == w_len));
  assign w_usr_e = w_fin & s00_axis_tuser;

  assign w_flags = r_flags | {w_usr_e, w_len_e,
                              w_kep_e, w_dat_e, w_seq_e};
  assign w_any   = |w_flags;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_IN_PKT: begin
        if (w_beat) begin
          if (s00_axis_tlast) begin
            w_state_nxt = S_IDLE;
          end else if (r_idx == w_len) begin
            w_state_nxt = S_DROP;
          end else begin
            w_state_nxt = S_IN_PKT;
          end
        end
      end
      S_DROP: begin
        if (w_fin) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_idx   <= '0;
      r_len_q <= '0;
      r_dat_q <= '0;
      r_flags <= '0;
    end else begin
      if (w_start) begin
        r_len_q <= packet_length;
        r_dat_q <= expected_data;
      end
      if (w_fin) begin
        r_idx   <= '0;
        r_flags <= '0;
      end else if (w_beat) begin
        r_flags <= w_flags;
        if (r_idx != 16'hFFFF) begin
          r_idx <= r_idx + 16'd1;
        end
      end
    end
  end

  // Clear outranks a same-cycle finish: that packet is simply lost.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_rx_cnt     <= '0;
      r_good_cnt   <= '0;
      r_seq_cnt    <= '0;
      r_dat_cnt    <= '0;
      r_kep_cnt    <= '0;
      r_len_cnt    <= '0;
      r_usr_cnt    <= '0;
      r_last_flags <= '0;
      r_err_pulse  <= 1'b0;
    end else if (clear_counters) begin
      r_rx_cnt     <= '0;
      r_good_cnt   <= '0;
      r_seq_cnt    <= '0;
      r_dat_cnt    <= '0;
      r_kep_cnt    <= '0;
      r_len_cnt    <= '0;
      r_usr_cnt    <= '0;
      r_last_flags <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_err_pulse <= w_fin & w_any;
      if (w_fin) begin
        r_rx_cnt     <= f_inc(r_rx_cnt, 1'b1);
        r_good_cnt   <= f_inc(r_good_cnt, !w_any);
        r_seq_cnt    <= f_inc(r_seq_cnt, w_flags[0]);
        r_dat_cnt    <= f_inc(r_dat_cnt, w_flags[1]);
        r_kep_cnt    <= f_inc(r_kep_cnt, w_flags[2]);
        r_len_cnt    <= f_inc(r_len_cnt, w_flags[3]);
        r_usr_cnt    <= f_inc(r_usr_cnt, w_flags[4]);
        r_last_flags <= w_flags;
      end
    end
  end

  assign rx_pkt_count   = r_rx_cnt;
  assign good_pkt_count = r_good_cnt;
  assign seq_err_count  = r_seq_cnt;
  assign data_err_count = r_dat_cnt;
  assign keep_err_count = r_kep_cnt;
  assign len_err_count  = r_len_cnt;
  assign user_err_count = r_usr_cnt;
  assign last_err_flags = r_last_flags;
  assign err_pulse      = r_err_pulse;

`ifdef PKT_CHK_GAP_STATS_EN
  logic [GAP_WIDTH-1:0] r_gap_cnt;
  logic [GAP_WIDTH-1:0] r_min_gap;
  logic [GAP_WIDTH-1:0] r_max_gap;
  logic                 r_gap_arm;

  // r_gap_arm marks that a previous packet end exists to measure from.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_gap_cnt <= '0;
      r_gap_arm <= 1'b0;
      r_min_gap <= '1;
      r_max_gap <= '0;
    end else begin
      if (w_fin) begin
        r_gap_cnt <= '0;
      end else if (!w_beat && (r_gap_cnt != '1)) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
      if (clear_counters) begin
        r_gap_arm <= 1'b0;
        r_min_gap <= '1;
        r_max_gap <= '0;
      end else begin
        if (w_fin) begin
          r_gap_arm <= 1'b1;
        end
        if (w_start && r_gap_arm) begin
          if (r_gap_cnt < r_min_gap) begin
            r_min_gap <= r_gap_cnt;
          end
          if (r_gap_cnt > r_max_gap) begin
            r_max_gap <= r_gap_cnt;
          end
        end
      end
    end
  end

  assign min_gap = r_min_gap;
  assign max_gap = r_max_gap;
`endif

endmodule

// File: tb/tb_eth_packet_checker.sv
// tb_eth_packet_checker: table, directed and random packets scored
// against a packet-level reference model.
`timescale 1ns/1ps
module tb_eth_packet_checker;

  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [47:0] DPAT = 48'hA5A5_0000_1234;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic [15:0] plen;
  logic [47:0] edata;
  logic        clr;
  logic [CW-1:0] rx, good, seqc, datc, kepc, lenc, usrc;
  logic [4:0]  lflags;
  logic        pulse;
`ifdef PKT_CHK_GAP_STATS_EN
  logic [15:0] min_gap, max_gap;
`endif

  always #5 clk = ~clk;

  eth_packet_checker #(.CNT_WIDTH(CW)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (tdata),
    .s00_axis_tkeep   (tkeep),
    .s00_axis_tvalid  (tvalid),
    .s00_axis_tlast   (tlast),
    .s00_axis_tuser   (tuser),
    .packet_length    (plen),
    .expected_data    (edata),
    .clear_counters   (clr),
    .rx_pkt_count     (rx),
    .good_pkt_count   (good),
    .seq_err_count    (seqc),
    .data_err_count   (datc),
    .keep_err_count   (kepc),
    .len_err_count    (lenc),
    .user_err_count   (usrc),
    .last_err_flags   (lflags),
    .err_pulse        (pulse)
`ifdef PKT_CHK_GAP_STATS_EN
    ,
    .min_gap          (min_gap),
    .max_gap          (max_gap)
`endif
  );

  int checks = 0;
  int failures = 0;
  int m_cnt[7];
  logic [4:0] m_last;
  int m_pulses = 0;
  int seen_pulses = 0;

  always @(negedge clk) if (pulse === 1'b1) seen_pulses++;

  typedef struct {
    int          n;
    logic [15:0] len;
    int          sb;
    int          db;
    int          kb;
    bit          user;
    logic [4:0]  ef;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_zero;
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    m_last = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rx"},    64'(rx),   64'(m_cnt[0]));
    chk({tag, ".good"},  64'(good), 64'(m_cnt[1]));
    chk({tag, ".seq"},   64'(seqc), 64'(m_cnt[2]));
    chk({tag, ".data"},  64'(datc), 64'(m_cnt[3]));
    chk({tag, ".keep"},  64'(kepc), 64'(m_cnt[4]));
    chk({tag, ".len"},   64'(lenc), 64'(m_cnt[5]));
    chk({tag, ".user"},  64'(usrc), 64'(m_cnt[6]));
    chk({tag, ".flags"}, 64'(lflags), 64'(m_last));
  endtask

  task automatic do_clear;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    model_zero();
    check_all("clear");
  endtask

  // Sends one packet of n beats; beats past index L are never judged.
  task automatic send(input int n, input logic [15:0] len,
                      input logic [47:0] d, input int sb,
                      input int db, input int kb, input bit user,
                      input int idle_max, input int gap,
                      input bit clr_last, input string tag,
                      output logic [4:0] fout);
    logic [4:0] f;
    f = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && idle_max > 0) begin
        repeat ($urandom_range(idle_max, 0)) begin
          tvalid = 1'b0;
          tlast  = 1'($urandom);
          tdata  = {$urandom(), $urandom()};
          cyc();
        end
      end
      tvalid = 1'b1;
      tdata  = {d, 16'(k)};
      if (k == sb) tdata[15:0] = 16'(k + 6);
      if (k == db) tdata[40] = ~tdata[40];
      tkeep  = (k == kb) ? 8'h0F : 8'hFF;
      tlast  = (k == n - 1);
      tuser  = tlast ? user : 1'($urandom);
      clr    = clr_last && tlast;
      if (k == 0) begin
        plen  = len;
        edata = d;
      end
      if (k <= int'(len)) begin
        if (tdata[15:0] != 16'(k)) f[0] = 1'b1;
        if (tdata[63:16] != d)     f[1] = 1'b1;
        if (tkeep != 8'hFF)        f[2] = 1'b1;
      end
      cyc();
      if (k == 0) begin
        plen  = 16'($urandom);
        edata = 48'({$urandom(), $urandom()});
      end
    end
    f[3] = (n - 1 != int'(len));
    f[4] = user;
    tvalid = 1'b0;
    tlast  = 1'b0;
    clr    = 1'b0;
    if (clr_last) begin
      model_zero();
    end else begin
      m_cnt[0] = sat(m_cnt[0]);
      if (f == 0) m_cnt[1] = sat(m_cnt[1]);
      for (int b = 0; b < 5; b++)
        if (f[b]) m_cnt[2 + b] = sat(m_cnt[2 + b]);
      m_last = f;
      if (f != 0) m_pulses++;
    end
    chk({tag, ".pulse"}, 64'(pulse),
        64'(!clr_last && (f != 0)));
    check_all(tag);
    if (gap > 0) begin
      cyc();
      chk({tag, ".pulse_end"}, 64'(pulse), 64'(0));
      repeat (gap - 1) cyc();
    end
    fout = f;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[11];
    logic [4:0] f;
    tbl[0]  = '{8, 16'd7, -1, -1, -1, 1'b0, 5'b00000};
    tbl[1]  = '{8, 16'd7,  3, -1, -1, 1'b0, 5'b00001};
    tbl[2]  = '{6, 16'd7, -1, -1, -1, 1'b0, 5'b01000};
    tbl[3]  = '{10, 16'd7, 8,  9, -1, 1'b0, 5'b01000};
    tbl[4]  = '{8, 16'd7, -1, -1,  2, 1'b1, 5'b10100};
    tbl[5]  = '{1, 16'd0, -1, -1, -1, 1'b0, 5'b00000};
    tbl[6]  = '{1, 16'd3, -1, -1, -1, 1'b0, 5'b01000};
    tbl[7]  = '{2, 16'd0, -1,  1, -1, 1'b0, 5'b01000};
    tbl[8]  = '{8, 16'd7, -1,  5, -1, 1'b0, 5'b00010};
    tbl[9]  = '{8, 16'd7,  0, -1, -1, 1'b0, 5'b00001};
    tbl[10] = '{8, 16'd7,  7, -1, -1, 1'b0, 5'b00001};

    rst_n = 1'b0;
    tdata = '0; tkeep = 8'hFF; tvalid = 1'b0; tlast = 1'b0;
    tuser = 1'b0; plen = 16'd7; edata = DPAT; clr = 1'b0;
    model_zero();
    repeat (3) cyc();
    check_all("reset");
    chk("reset.pulse", 64'(pulse), 64'(0));
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 10; i++)
      send(8, 16'd7, DPAT, -1, -1, -1, 1'b0, 0, 0, 1'b0, "clean", f);
    chk("clean.rx10", 64'(rx), 64'(10));
    chk("clean.no_pulse", 64'(seen_pulses), 64'(0));
    do_clear();

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].n, tbl[i].len, DPAT, tbl[i].sb, tbl[i].db,
           tbl[i].kb, tbl[i].user, 0, i % 3, 1'b0, "tbl", f);
      chk($sformatf("tbl%0d.flags", i), 64'(lflags), 64'(tbl[i].ef));
    end

    send(8, 16'd7, DPAT, 3, -1, -1, 1'b1, 0, 2, 1'b1, "clrfin", f);
    send(8, 16'd7, DPAT, -1, -1, -1, 1'b0, 0, 1, 1'b0, "postclr", f);
    chk("postclr.good1", 64'(good), 64'(1));

    for (int i = 0; i < 200; i++) begin
      send($urandom_range(12, 1), 16'($urandom_range(11, 0)),
           48'({$urandom(), $urandom()}),
           ($urandom_range(3, 0) == 0) ? $urandom_range(11, 0) : -1,
           ($urandom_range(3, 0) == 0) ? $urandom_range(11, 0) : -1,
           ($urandom_range(3, 0) == 0) ? $urandom_range(11, 0) : -1,
           ($urandom_range(7, 0) == 0), 2, $urandom_range(3, 0),
           ($urandom_range(19, 0) == 0), "rnd", f);
    end

    do_clear();
    for (int i = 0; i < 300; i++)
      send(1, 16'd0, DPAT, -1, -1, -1, 1'b1, 0, 0, 1'b0, "sat", f);
    chk("sat.rx", 64'(rx), 64'(SAT));
    chk("sat.good", 64'(good), 64'(0));

    for (int k = 0; k < 4; k++) begin
      tvalid = 1'b1; tdata = {DPAT, 16'(k)}; tkeep = 8'hFF;
      tlast = 1'b0; tuser = 1'b0; plen = 16'd7; edata = DPAT;
      cyc();
    end
    tdata = {DPAT, 16'd4};
    #2;
    rst_n = 1'b0;
    #1;
    model_zero();
    check_all("async_rst");
    cyc();
    rst_n = 1'b1;
    tvalid = 1'b0;
    cyc();
    send(8, 16'd7, DPAT, -1, -1, -1, 1'b0, 0, 3, 1'b0, "rst_a", f);
    chk("rst_a.good", 64'(good), 64'(1));
`ifdef PKT_CHK_GAP_STATS_EN
    chk("gap.min_init", 64'(min_gap), 64'(16'hFFFF));
    chk("gap.max_init", 64'(max_gap), 64'(0));
`endif
    send(8, 16'd7, DPAT, -1, -1, -1, 1'b0, 0, 10, 1'b0, "rst_b", f);
    send(8, 16'd7, DPAT, -1, -1, -1, 1'b0, 0, 1, 1'b0, "rst_c", f);
`ifdef PKT_CHK_GAP_STATS_EN
    chk("gap.min", 64'(min_gap), 64'(3));
    chk("gap.max", 64'(max_gap), 64'(10));
`endif
    cyc();
    chk("pulse_count", 64'(seen_pulses), 64'(m_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
